demux_12_stream: RTL and testbench
==================================

// Module: demux_12_stream
// PURPOSE
//  Registered 1-to-2 stream demultiplexer; the inverse of the 2:1 mux (mux_21).
//  - One valid/ready input stream is steered by in_sel to one of two output streams.
//  - Each output has a one-entry holding register, so back-pressure is applied per channel.
//  - Sits between a single producer and two consumers on the datapath.
// PARAMETERS
//  WIDTH  8  data width of input and both outputs
//  CNT_W  8  width of per-channel transfer counters (only with DEMUX_CNT_EN)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active low
//  in_data     in   WIDTH  input word
//  in_sel      in   1      0 -> channel 0, 1 -> channel 1
//  in_valid    in   1      input word present
//  in_ready    out  1      demux accepts the word this cycle
//  out0_data   out  WIDTH  channel 0 word (registered)
//  out0_valid  out  1      channel 0 holding register full
//  out0_ready  in   1      channel 0 consumer accepts
//  out1_data   out  WIDTH  channel 1 word (registered)
//  out1_valid  out  1      channel 1 holding register full
//  out1_ready  in   1      channel 1 consumer accepts
//  cnt0        out  CNT_W  words accepted into channel 0 (DEMUX_CNT_EN only)
//  cnt1        out  CNT_W  words accepted into channel 1 (DEMUX_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, takes effect immediately, no clock needed):
//    - outN_valid=0, outN_data=0, cnt0=cnt1=0.
//    - Words held at reset are discarded. Operation resumes on the first clk edge after rst_n=1.
//  - Per-channel state is EMPTY (outN_valid=0) or FULL (outN_valid=1).
//  - Drain: a channel drains in a cycle when outN_valid and outN_ready are both 1.
//  - in_ready is combinational from in_sel and the selected channel only:
//    - in_ready = !out[sel]_valid || out[sel]_ready.
//    - The unselected channel's state never affects in_ready.
//  - Accept: the input is accepted when in_valid && in_ready. On that clk edge:
//    - out[sel]_data <= in_data and out[sel]_valid <= 1.
//    - Latency is 1 cycle.
//  - Transitions for each channel at a clk edge:
//    - EMPTY + load -> FULL.
//    - FULL + drain, no load -> EMPTY.
//    - FULL + drain + load (same cycle) -> FULL with the new word (no bubble).
//    - FULL + no drain -> FULL. outN_data must be held stable while outN_valid && !outN_ready.
//  - The unselected channel can drain in the same cycle the selected channel loads.
//  - Producer rule: in_data and in_sel stay stable while in_valid && !in_ready.
//  - in_valid=0: no state change apart from drains. in_ready still reflects the selected channel.
//  - Each channel delivers words in the order they were accepted. No word is dropped or duplicated.
// CONFIGURATION
//  DEMUX_CNT_EN defined:
//  - Ports cnt0 and cnt1 exist.
//  - cntN increments by 1 on each accept into channel N, and wraps from 2^CNT_W-1 to 0.
//  - Reset value is 0.
//  DEMUX_CNT_EN undefined:
//  - Ports cnt0 and cnt1 and the counter logic are absent.
//  - Stream behaviour is identical.
// TESTING
//  - Reset: assert rst_n=0 while both channels are FULL.
//    -> out0_valid=out1_valid=0 and data=0 immediately, without a clk edge.
//  - Basic steer, both consumers ready:
//    - in_data=8'hA5 with sel=0, then 8'h3C with sel=1.
//    - -> out0_data=A5 valid one cycle after accept; out1_data=3C one cycle after its accept.
//  - Back-pressure: out0_ready=0 and two sel=0 words (8'h11, 8'h22).
//    - -> first word held as out0_data=11; in_ready=0 for the second word.
//    - -> releasing out0_ready delivers 11 then 22 with no bubble.
//  - Independence: channel 0 FULL with out0_ready=0, then sel=1 word 8'h77.
//    -> in_ready=1 and out1_data=77 the next cycle; channel 0 is unchanged.
//  - Simultaneous drain and load: channel 0 FULL with 8'h01, out0_ready=1, and a sel=0 word 8'h02.
//    -> accepted in that cycle; out0_valid stays 1 and out0_data=02 the next cycle.
//  - DEMUX_CNT_EN with CNT_W=2: five accepts on channel 0.
//    -> cnt0 goes 1,2,3,0,1 and cnt1 stays 0.

Source files
------------

// File: rtl/demux_12_stream.sv
// Registered 1-to-2 valid/ready stream demux with a one-entry register per channel.
// Optional per-channel accept counters are enabled by defining DEMUX_CNT_EN.
module demux_12_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic sel_full;
  logic sel_rdy;
  logic acc;
  logic ld0;
  logic ld1;

  // Only the steered channel decides whether the input can move.
  always_comb begin
    sel_full = 1'b0;
    sel_rdy  = 1'b0;
    unique case (in_sel)
      1'b0: begin
        sel_full = out0_valid;
        sel_rdy  = out0_ready;
      end
      1'b1: begin
        sel_full = out1_valid;
        sel_rdy  = out1_ready;
      end
      default: ;
    endcase
  end

  assign in_ready = !sel_full || sel_rdy;
  assign acc      = in_valid && in_ready;
  assign ld0      = acc && !in_sel;
  assign ld1      = acc && in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (ld0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (ld1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (ld0) cnt0 <= cnt0 + 1'b1;
      if (ld1) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_12_stream.sv
// Scoreboard bench for demux_12_stream.
// Counter checks are built when DEMUX_CNT_EN is defined.
module tb_demux_12_stream;

`ifdef DEMUX_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  int n_chk;
  int n_fail;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  demux_12_stream #(.WIDTH(8), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0_data(out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drains pop the expected word; accepts push the new one.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        n_chk++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb_ch0 unexpected word %h", out0_data);
        end else begin
          e = q0.pop_front();
          if (out0_data !== e) begin
            n_fail++;
            $display("FAIL sb_ch0 got %h exp %h", out0_data, e);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        n_chk++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb_ch1 unexpected word %h", out1_data);
        end else begin
          e = q1.pop_front();
          if (out1_data !== e) begin
            n_fail++;
            $display("FAIL sb_ch1 got %h exp %h", out1_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic s);
    int n;
    n = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout got in_ready=0 exp 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    n_chk++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b%b exp 00",
               out0_valid, out1_valid);
    end
    n_chk++;
    if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h %h exp 00 00",
               out0_data, out1_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(8'hA5, 1'b0);
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_ch0 got v=%b d=%h exp v=1 d=a5",
               out0_valid, out0_data);
    end
    send(8'h3C, 1'b1);
    n_chk++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL basic_ch1 got v=%b d=%h exp v=1 d=3c",
               out1_valid, out1_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0;
    send(8'h11, 1'b0);
    in_data  = 8'h22;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready got %b exp 0", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out0_data !== 8'h11 || out0_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold got v=%b d=%h exp v=1 d=11",
               out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got in_ready=%b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h22) begin
      n_fail++;
      $display("FAIL bp_nobubble got v=%b d=%h exp v=1 d=22",
               out0_valid, out0_data);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (out0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty got v=%b exp 0", out0_valid);
    end
  endtask

  task automatic test_independence();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'h55, 1'b0);
    in_data  = 8'h77;
    in_sel   = 1'b1;
    in_valid = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ind_in_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_chk++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h77) begin
      n_fail++;
      $display("FAIL ind_ch1 got v=%b d=%h exp v=1 d=77",
               out1_valid, out1_data);
    end
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h55) begin
      n_fail++;
      $display("FAIL ind_ch0 got v=%b d=%h exp v=1 d=55",
               out0_valid, out0_data);
    end
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain_load();
    out0_ready = 1'b0;
    send(8'h01, 1'b0);
    out0_ready = 1'b1;
    in_data    = 8'h02;
    in_sel     = 1'b0;
    in_valid   = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dl_in_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_chk++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h02) begin
      n_fail++;
      $display("FAIL dl_ch0 got v=%b d=%h exp v=1 d=02",
               out0_valid, out0_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic acc;
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_sel   = 1'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_leftover got %0d %0d exp 0 0",
               q0.size(), q1.size());
    end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter();
    logic [CNT_W-1:0] e;
    do_reset();
    n_chk++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      n_fail++;
      $display("FAIL cnt_reset got %0d %0d exp 0 0", cnt0, cnt1);
    end
    out0_ready = 1'b1;
    e = '0;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h40 + i), 1'b0);
      e = e + 1'b1;
      n_chk++;
      if (cnt0 !== e || cnt1 !== '0) begin
        n_fail++;
        $display("FAIL cnt_step%0d got %0d %0d exp %0d 0",
                 i, cnt0, cnt1, e);
      end
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_independence();
    test_drain_load();
    test_back_to_back();
`ifdef DEMUX_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
